// File: rtl/kd_tree_search_pipe.sv
// Fully pipelined KD-tree traversal: one query per cycle walks DEPTH levels of internal nodes
// (split dimension + signed median) and emits the leaf index with the original patch.
module kd_tree_search_pipe #(
    parameter int unsigned DATA_WIDTH  = 11,
    parameter int unsigned NUM_DIMS    = 5,
    parameter int unsigned DEPTH       = 6,
    parameter int unsigned IDX_WIDTH   = $clog2(NUM_DIMS),
    parameter int unsigned PATCH_WIDTH = DATA_WIDTH * NUM_DIMS
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cfg_clear_i,
    input  logic                            cfg_valid_i,
    output logic                            cfg_ready_o,
    input  logic [DATA_WIDTH+IDX_WIDTH-1:0] cfg_data_i,
    output logic                            tree_loaded_o,
    input  logic                            patch_valid_i,
    output logic                            patch_ready_o,
    input  logic [PATCH_WIDTH-1:0]          patch_in_i,
    output logic                            leaf_valid_o,
    input  logic                            leaf_ready_i,
    output logic [DEPTH-1:0]                leaf_index_o,
    output logic [PATCH_WIDTH-1:0]          patch_out_o
);

    localparam int unsigned NumNodes = 2 ** DEPTH - 1;

    logic signed [DATA_WIDTH-1:0] med_q   [NumNodes];
    logic        [IDX_WIDTH-1:0]  split_q [NumNodes];

    logic [DEPTH-1:0]       wr_ptr_q, wr_ptr_d;
    logic                   loaded_q, loaded_d;
    logic [DEPTH-1:0]       st_valid_q, st_valid_d;
    logic [PATCH_WIDTH-1:0] st_patch_q [DEPTH];
    logic [PATCH_WIDTH-1:0] st_patch_d [DEPTH];
    logic [DEPTH-1:0]       st_path_q  [DEPTH];
    logic [DEPTH-1:0]       st_path_d  [DEPTH];
    logic                   leaf_valid_q, leaf_valid_d;
    logic [DEPTH-1:0]       leaf_index_q, leaf_index_d;
    logic [PATCH_WIDTH-1:0] patch_out_q, patch_out_d;

    logic [DEPTH-1:0] right;
    logic [DEPTH-1:0] next_path [DEPTH];
    logic             stall, pipe_empty, cfg_fire, patch_fire, last_node;

    // Split indices beyond the last dimension read as component value 0.
    function automatic logic signed [DATA_WIDTH-1:0] sel_comp(
        input logic [PATCH_WIDTH-1:0] patch,
        input logic [IDX_WIDTH-1:0]   idx
    );
        logic signed [DATA_WIDTH-1:0] res;
        res = '0;
        for (int d = 0; d < NUM_DIMS; d++) begin
            if (idx == IDX_WIDTH'(d)) res = patch[d*DATA_WIDTH +: DATA_WIDTH];
        end
        return res;
    endfunction

    assign stall         = leaf_valid_q & ~leaf_ready_i;
    assign pipe_empty    = ~(|st_valid_q) & ~leaf_valid_q;
    assign cfg_ready_o   = ~loaded_q & pipe_empty;
    assign patch_ready_o = loaded_q & ~stall & ~cfg_clear_i;
    assign cfg_fire      = cfg_valid_i & cfg_ready_o & ~cfg_clear_i;
    assign patch_fire    = patch_valid_i & patch_ready_o;
    assign last_node     = (wr_ptr_q == DEPTH'(NumNodes - 1));

    assign tree_loaded_o = loaded_q;
    assign leaf_valid_o  = leaf_valid_q;
    assign leaf_index_o  = leaf_index_q;
    assign patch_out_o   = patch_out_q;

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        logic        [DEPTH-1:0]      node;
        logic signed [DATA_WIDTH-1:0] comp;
        assign node         = DEPTH'((2 ** s) - 1) + st_path_q[s];
        assign comp         = sel_comp(st_patch_q[s], split_q[node]);
        assign right[s]     = !(comp < med_q[node]);
        assign next_path[s] = (st_path_q[s] << 1) | DEPTH'(right[s]);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        loaded_d = loaded_q;
        if (cfg_clear_i && pipe_empty) begin
            wr_ptr_d = '0;
            loaded_d = 1'b0;
        end else if (cfg_fire) begin
            wr_ptr_d = last_node ? '0 : wr_ptr_q + 1'b1;
            loaded_d = last_node;
        end
    end

    // A stall freezes every stage and the output register together.
    always_comb begin
        st_valid_d   = st_valid_q;
        st_patch_d   = st_patch_q;
        st_path_d    = st_path_q;
        leaf_valid_d = leaf_valid_q;
        leaf_index_d = leaf_index_q;
        patch_out_d  = patch_out_q;
        if (!stall) begin
            st_valid_d[0] = patch_fire;
            st_patch_d[0] = patch_in_i;
            st_path_d[0]  = '0;
            for (int s = 1; s < DEPTH; s++) begin
                st_valid_d[s] = st_valid_q[s-1];
                st_patch_d[s] = st_patch_q[s-1];
                st_path_d[s]  = next_path[s-1];
            end
            leaf_valid_d = st_valid_q[DEPTH-1];
            if (st_valid_q[DEPTH-1]) begin
                leaf_index_d = next_path[DEPTH-1];
                patch_out_d  = st_patch_q[DEPTH-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            loaded_q     <= 1'b0;
            st_valid_q   <= '0;
            leaf_valid_q <= 1'b0;
            leaf_index_q <= '0;
            patch_out_q  <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                st_patch_q[s] <= '0;
                st_path_q[s]  <= '0;
            end
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            loaded_q     <= loaded_d;
            st_valid_q   <= st_valid_d;
            st_patch_q   <= st_patch_d;
            st_path_q    <= st_path_d;
            leaf_valid_q <= leaf_valid_d;
            leaf_index_q <= leaf_index_d;
            patch_out_q  <= patch_out_d;
        end
    end

    // Node storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (cfg_fire) begin
            med_q[wr_ptr_q]   <= cfg_data_i[DATA_WIDTH+IDX_WIDTH-1:IDX_WIDTH];
            split_q[wr_ptr_q] <= cfg_data_i[IDX_WIDTH-1:0];
        end
    end

endmodule
